// File: rtl/bpsk_mod_text_if.sv
// Handshake bundle for the text-link BPSK mapper.
// Carries the word input (valid/ready), the symbol output (valid/ready/last)
// and the busy flag. When BPSK_MOD_PACKED_OUT_EN is defined, the bundle also
// carries the packed whole-word output.
// The master modport is the side that feeds words and sinks symbols.
// The slave modport is the mapper itself.
interface bpsk_mod_text_if #(
    parameter int n = 12
);
    logic [n-1:0]   DataIn;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     sym_out;
    logic           sym_valid;
    logic           sym_ready;
    logic           sym_last;
    logic           busy;
`ifdef BPSK_MOD_PACKED_OUT_EN
    logic [2*n-1:0] packed_out;
    logic           packed_valid;
`endif

    modport master (
        output DataIn,
        output in_valid,
        input  in_ready,
        input  sym_out,
        input  sym_valid,
        output sym_ready,
        input  sym_last,
        input  busy
`ifdef BPSK_MOD_PACKED_OUT_EN
        ,
        input  packed_out,
        input  packed_valid
`endif
    );

    modport slave (
        input  DataIn,
        input  in_valid,
        output in_ready,
        output sym_out,
        output sym_valid,
        input  sym_ready,
        output sym_last,
        output busy
`ifdef BPSK_MOD_PACKED_OUT_EN
        ,
        output packed_out,
        output packed_valid
`endif
    );
endinterface

// File: rtl/bpsk_mod_text.sv
// BPSK symbol mapper for the text link.
// The mapper accepts one n-bit word, then emits it LSB first as one 2-bit
// symbol per accepted beat: bit 0 gives SYM_ZERO and bit 1 gives SYM_ONE.
// A new word may be taken on the last beat, so words run back to back with
// no gap. in_ready is combinational from sym_ready on purpose, because that
// path enables the back-to-back handoff.
// Optional macro BPSK_MOD_PACKED_OUT_EN adds packed_out/packed_valid. These
// present the whole word's symbols in demodulator bit order once the word
// completes.
module bpsk_mod_text #(
    parameter int          n        = 12,
    parameter logic [1:0]  SYM_ZERO = 2'b01,
    parameter logic [1:0]  SYM_ONE  = 2'b10
) (
    input  logic              clk,
    input  logic              rst_n,
    bpsk_mod_text_if.slave    bus
);
    localparam int             CW       = $clog2(n) + 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(n - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [n-1:0]    shift_r;
    logic [n-1:0]    shift_nxt_s;
    logic [CW-1:0]   bit_cnt_r;
    logic [CW-1:0]   bit_cnt_nxt_s;
    logic [1:0]      sym_out_r;
    logic            sym_valid_r;
    logic            sym_last_r;
    logic            busy_r;
    logic            in_ready_s;
    logic            beat_s;

    // Map one data bit onto its channel symbol.
    function automatic logic [1:0] map_bit(input logic b);
        return b ? SYM_ONE : SYM_ZERO;
    endfunction

    // Word acceptance and beat completion qualifiers.
    always_comb begin
        in_ready_s = (state_r == ST_IDLE) ||
                     ((state_r == ST_SEND) && sym_last_r && bus.sym_ready);
        beat_s     = sym_valid_r && bus.sym_ready;
    end

    // Next state, shift register and bit counter.
    always_comb begin
        state_nxt_s   = state_r;
        shift_nxt_s   = shift_r;
        bit_cnt_nxt_s = bit_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_nxt_s   = ST_SEND;
                    shift_nxt_s   = bus.DataIn;
                    bit_cnt_nxt_s = {CW{1'b0}};
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (beat_s && sym_last_r) begin
                    if (bus.in_valid) begin
                        // Back-to-back word: reload without leaving SEND.
                        state_nxt_s   = ST_SEND;
                        shift_nxt_s   = bus.DataIn;
                        bit_cnt_nxt_s = {CW{1'b0}};
                    end else begin
                        state_nxt_s   = ST_IDLE;
                        shift_nxt_s   = shift_r >> 1;
                        bit_cnt_nxt_s = {CW{1'b0}};
                    end
                end else if (beat_s) begin
                    shift_nxt_s   = shift_r >> 1;
                    bit_cnt_nxt_s = bit_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    // Downstream stalled: hold symbol and position.
                    shift_nxt_s   = shift_r;
                    bit_cnt_nxt_s = bit_cnt_r;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                shift_nxt_s   = {n{1'b0}};
                bit_cnt_nxt_s = {CW{1'b0}};
            end
        endcase
    end

    // State and registered symbol outputs, derived from the next state so
    // the first symbol appears the cycle after the word is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            shift_r     <= {n{1'b0}};
            bit_cnt_r   <= {CW{1'b0}};
            sym_out_r   <= 2'b00;
            sym_valid_r <= 1'b0;
            sym_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            shift_r     <= shift_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            sym_out_r   <= (state_nxt_s == ST_SEND) ? map_bit(shift_nxt_s[0]) : 2'b00;
            sym_valid_r <= (state_nxt_s == ST_SEND);
            sym_last_r  <= (state_nxt_s == ST_SEND) && (bit_cnt_nxt_s == LAST_CNT);
            busy_r      <= (state_nxt_s == ST_SEND);
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.sym_out   = sym_out_r;
    assign bus.sym_valid = sym_valid_r;
    assign bus.sym_last  = sym_last_r;
    assign bus.busy      = busy_r;

`ifdef BPSK_MOD_PACKED_OUT_EN
    logic [2*n-1:0]  acc_r;
    logic [2*n-1:0]  acc_ins_s;
    logic [2*n-1:0]  packed_out_r;
    logic            packed_valid_r;
    logic            last_beat_s;

    // Accumulator with the current symbol dropped into its bit slot.
    always_comb begin
        acc_ins_s   = acc_r;
        last_beat_s = beat_s && sym_last_r;
        for (int i = 0; i < n; i++) begin
            if (bit_cnt_r == CW'(i)) begin
                acc_ins_s[2*i +: 2] = sym_out_r;
            end else begin
                acc_ins_s[2*i +: 2] = acc_r[2*i +: 2];
            end
        end
    end

    // Collect symbols per beat; publish the word when its last beat completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r          <= {(2*n){1'b0}};
            packed_out_r   <= {(2*n){1'b0}};
            packed_valid_r <= 1'b0;
        end else begin
            acc_r          <= beat_s ? acc_ins_s : acc_r;
            packed_out_r   <= last_beat_s ? acc_ins_s : packed_out_r;
            packed_valid_r <= last_beat_s;
        end
    end

    assign bus.packed_out   = packed_out_r;
    assign bus.packed_valid = packed_valid_r;
`endif

endmodule

// File: tb/tb_bpsk_mod_text.sv
// Self-checking bench for bpsk_mod_text.
// The reference model keeps the bits still to be sent as a queue and predicts
// every output each cycle. Directed cases and random traffic run on an n=12
// instance; a second n=15 instance covers the BCH word width.
module tb_bpsk_mod_text;
    localparam int N  = 12;
    localparam int N2 = 15;

    logic clk;
    logic rst_n;
    int   chk_cnt;
    int   err_cnt;

    bpsk_mod_text_if #(.n(N))  bus();
    bpsk_mod_text_if #(.n(N2)) bus15();

    bpsk_mod_text #(.n(N))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    bpsk_mod_text #(.n(N2)) dut15 (.clk(clk), .rst_n(rst_n), .bus(bus15));

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state.
    bit          bits_q[$];
    logic [N-1:0] cur_word;
    logic [31:0] exp_packed;
    bit          exp_pvalid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_word(input logic [N-1:0] w);
        logic [31:0] p;
        p = 32'h0;
        for (int i = 0; i < N; i++) begin
            p[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
        end
        return p;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, step the model.
    task automatic cycle(input bit dv, input logic [N-1:0] din, input bit sr);
        bit         rdy_exp;
        bit         done;
        logic [1:0] so_exp;
        bus.in_valid  = dv;
        bus.DataIn    = din;
        bus.sym_ready = sr;
        #1;
        so_exp  = (bits_q.size() == 0) ? 2'b00 : (bits_q[0] ? 2'b10 : 2'b01);
        rdy_exp = (bits_q.size() == 0) || ((bits_q.size() == 1) && sr);
        check_eq("sym_valid", {31'b0, bus.sym_valid}, {31'b0, bits_q.size() != 0});
        check_eq("sym_out",   {30'b0, bus.sym_out},   {30'b0, so_exp});
        check_eq("sym_last",  {31'b0, bus.sym_last},  {31'b0, bits_q.size() == 1});
        check_eq("busy",      {31'b0, bus.busy},      {31'b0, bits_q.size() != 0});
        check_eq("in_ready",  {31'b0, bus.in_ready},  {31'b0, rdy_exp});
`ifdef BPSK_MOD_PACKED_OUT_EN
        check_eq("packed_valid", {31'b0, bus.packed_valid}, {31'b0, exp_pvalid});
        check_eq("packed_out",   32'(bus.packed_out),       exp_packed);
`endif
        @(posedge clk);
        done = 1'b0;
        if ((bits_q.size() > 0) && sr) begin
            done = (bits_q.size() == 1);
            void'(bits_q.pop_front());
        end
        exp_pvalid = done;
        if (done) begin
            exp_packed = pack_word(cur_word);
        end
        if (dv && rdy_exp) begin
            cur_word = din;
            for (int i = 0; i < N; i++) begin
                bits_q.push_back(din[i]);
            end
        end
        #1;
    endtask

    initial begin
        chk_cnt    = 0;
        err_cnt    = 0;
        exp_packed = 32'h0;
        exp_pvalid = 1'b0;
        cur_word   = '0;
        bus.in_valid    = 1'b0;
        bus.DataIn      = '0;
        bus.sym_ready   = 1'b1;
        bus15.in_valid  = 1'b0;
        bus15.DataIn    = '0;
        bus15.sym_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        check_eq("rst_sym_valid", {31'b0, bus.sym_valid}, 32'h0);
        check_eq("rst_sym_out",   {30'b0, bus.sym_out},   32'h0);
        check_eq("rst_busy",      {31'b0, bus.busy},      32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word, downstream always ready.
        cycle(1'b1, 12'hA5C, 1'b1);
        for (int i = 0; i < 14; i++) cycle(1'b0, 12'h000, 1'b1);
`ifdef BPSK_MOD_PACKED_OUT_EN
        check_eq("packed_a5c", 32'(bus.packed_out), 32'h009966A5);
`endif

        // Back-to-back words with in_valid held.
        cycle(1'b1, 12'h000, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b1, 12'hFFF, 1'b1);
        for (int i = 0; i < 13; i++) cycle(1'b0, 12'h000, 1'b1);

        // Stall for 3 cycles at beat 5.
        cycle(1'b1, 12'h001, 1'b1);
        for (int i = 0; i < 5; i++)  cycle(1'b0, 12'h000, 1'b1);
        for (int i = 0; i < 3; i++)  cycle(1'b0, 12'h000, 1'b0);
        for (int i = 0; i < 9; i++)  cycle(1'b0, 12'h000, 1'b1);

        // in_valid raised mid-word must be ignored.
        cycle(1'b1, 12'h3C5, 1'b1);
        for (int i = 0; i < 4; i++)  cycle(1'b0, 12'h000, 1'b1);
        for (int i = 0; i < 5; i++)  cycle(1'b1, 12'hFFF, 1'b1);
        for (int i = 0; i < 5; i++)  cycle(1'b0, 12'h000, 1'b1);

        // Asynchronous reset in the middle of a word.
        cycle(1'b1, 12'h6B3, 1'b1);
        for (int i = 0; i < 6; i++)  cycle(1'b0, 12'h000, 1'b1);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_sym_valid", {31'b0, bus.sym_valid}, 32'h0);
        check_eq("async_sym_out",   {30'b0, bus.sym_out},   32'h0);
        check_eq("async_sym_last",  {31'b0, bus.sym_last},  32'h0);
        check_eq("async_busy",      {31'b0, bus.busy},      32'h0);
        bits_q.delete();
        exp_pvalid = 1'b0;
        exp_packed = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 12'h800, 1'b1);
        for (int i = 0; i < 13; i++) cycle(1'b0, 12'h000, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 1) == 1, N'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 40; i++) cycle(1'b0, 12'h000, 1'b1);

        // BCH width: n=15, word 15'h4001.
        bus15.DataIn   = 15'h4001;
        bus15.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus15.in_valid = 1'b0;
        for (int i = 0; i < N2; i++) begin
            logic [14:0] w;
            w = 15'h4001;
            check_eq("n15_sym_valid", {31'b0, bus15.sym_valid}, 32'h1);
            check_eq("n15_sym_out", {30'b0, bus15.sym_out}, w[i] ? 32'h2 : 32'h1);
            check_eq("n15_sym_last", {31'b0, bus15.sym_last}, {31'b0, i == N2 - 1});
            @(posedge clk);
            #1;
        end
        check_eq("n15_idle", {31'b0, bus15.sym_valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end
endmodule
